// File: rtl/control_word_registers_8259.sv
// rtl/control_word_registers_8259.sv - 8259A control-word sequencer and configuration register file
//
// Purpose:
//   Detects rising edges of the write strobes from the read/write decode stage,
//   walks the ICW1 -> ICW2 -> (ICW3) -> (ICW4) initialisation sequence, holds all
//   programmed configuration (ICW fields, IMR, OCW3 selects) and emits single-cycle
//   OCW2/OCW3 command pulses to the priority and in-service logic.
//
// Ports:
//   clock, reset_n                     clock (rising edge), asynchronous active-low reset
//   write_initial_command_word_1       ICW1 strobe
//   write_initial_command_word_2_4     A0=1 strobe, ICW2-4 role
//   write_operation_control_word_1     A0=1 strobe, OCW1 role
//   write_operation_control_word_2/3   OCW2 / OCW3 strobes
//   internal_data_bus[7:0]             latched write data
//   initialization_complete            sequence finished
//   level_or_edge_triggered_config,
//   single_mode                        ICW1 LTIM / SNGL
//   interrupt_vector_address[4:0]      ICW2 D7:D3
//   cascade_device_config[7:0]         ICW3 byte
//   buffered_mode, buffered_master,
//   special_fully_nested, auto_eoi,
//   microprocessor_mode                ICW4 fields
//   interrupt_mask[7:0]                IMR
//   special_mask_mode, read_register_isr   OCW3 state
//   rotate_on_auto_eoi                 OCW2 rotate-in-AEOI flag
//   end_of_interrupt, set_priority,
//   poll_command                       one-cycle command pulses
//   specific_command, rotate_command   qualifiers valid with the pulses
//   command_level[2:0]                 OCW2 L2:L0

module control_word_registers_8259 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  input  logic [7:0] internal_data_bus,
  output logic       initialization_complete,
  output logic       level_or_edge_triggered_config,
  output logic       single_mode,
  output logic [4:0] interrupt_vector_address,
  output logic [7:0] cascade_device_config,
  output logic       buffered_mode,
  output logic       buffered_master,
  output logic       special_fully_nested,
  output logic       auto_eoi,
  output logic       microprocessor_mode,
  output logic [7:0] interrupt_mask,
  output logic       special_mask_mode,
  output logic       read_register_isr,
  output logic       rotate_on_auto_eoi,
  output logic       end_of_interrupt,
  output logic       specific_command,
  output logic       rotate_command,
  output logic       set_priority,
  output logic [2:0] command_level,
  output logic       poll_command
);

  typedef enum logic [2:0] {
    WAIT_ICW1 = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Previous strobe levels; reset to 1 so a strobe already high when reset
  // releases is not mistaken for a fresh write.
  logic prev_icw1_q, prev_icw1_d;
  logic prev_icw24_q, prev_icw24_d;
  logic prev_ocw1_q, prev_ocw1_d;
  logic prev_ocw2_q, prev_ocw2_d;
  logic prev_ocw3_q, prev_ocw3_d;

  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic [4:0] vector_q, vector_d;
  logic [7:0] cascade_q, cascade_d;
  logic       sfnm_q, sfnm_d;
  logic       buf_q, buf_d;
  logic       ms_q, ms_d;
  logic       aeoi_q, aeoi_d;
  logic       upm_q, upm_d;
  logic [7:0] imr_q, imr_d;
  logic       smm_q, smm_d;
  logic       ris_q, ris_d;
  logic       raeoi_q, raeoi_d;
  logic       eoi_q, eoi_d;
  logic       specific_q, specific_d;
  logic       rotate_q, rotate_d;
  logic       setpri_q, setpri_d;
  logic [2:0] level_q, level_d;
  logic       poll_q, poll_d;

  logic icw1_ev;
  logic a0_ev;
  logic ocw2_ev;
  logic ocw3_ev;

  always_comb begin
    icw1_ev = write_initial_command_word_1 & ~prev_icw1_q;
    // Both A0=1 strobes mean the same physical write; OR-ing them makes a
    // simultaneous rise count as a single event.
    a0_ev   = (write_initial_command_word_2_4 & ~prev_icw24_q) |
              (write_operation_control_word_1 & ~prev_ocw1_q);
    ocw2_ev = write_operation_control_word_2 & ~prev_ocw2_q;
    ocw3_ev = write_operation_control_word_3 & ~prev_ocw3_q;
  end

  always_comb begin
    state_d      = state_q;
    prev_icw1_d  = write_initial_command_word_1;
    prev_icw24_d = write_initial_command_word_2_4;
    prev_ocw1_d  = write_operation_control_word_1;
    prev_ocw2_d  = write_operation_control_word_2;
    prev_ocw3_d  = write_operation_control_word_3;
    ltim_d       = ltim_q;
    sngl_d       = sngl_q;
    ic4_d        = ic4_q;
    vector_d     = vector_q;
    cascade_d    = cascade_q;
    sfnm_d       = sfnm_q;
    buf_d        = buf_q;
    ms_d         = ms_q;
    aeoi_d       = aeoi_q;
    upm_d        = upm_q;
    imr_d        = imr_q;
    smm_d        = smm_q;
    ris_d        = ris_q;
    raeoi_d      = raeoi_q;
    level_d      = level_q;
    // Pulses and their qualifiers only live for the cycle after an event.
    eoi_d        = 1'b0;
    specific_d   = 1'b0;
    rotate_d     = 1'b0;
    setpri_d     = 1'b0;
    poll_d       = 1'b0;

    if (icw1_ev) begin
      // ICW1 restarts initialisation from any state.
      ltim_d  = internal_data_bus[3];
      sngl_d  = internal_data_bus[1];
      ic4_d   = internal_data_bus[0];
      imr_d   = 8'h00;
      smm_d   = 1'b0;
      ris_d   = 1'b0;
      raeoi_d = 1'b0;
      sfnm_d  = 1'b0;
      buf_d   = 1'b0;
      ms_d    = 1'b0;
      aeoi_d  = 1'b0;
      upm_d   = 1'b0;
      state_d = WAIT_ICW2;
    end else begin
      if (a0_ev) begin
        case (state_q)
          WAIT_ICW2: begin
            vector_d = internal_data_bus[7:3];
            if (!sngl_q)    state_d = WAIT_ICW3;
            else if (ic4_q) state_d = WAIT_ICW4;
            else            state_d = READY;
          end
          WAIT_ICW3: begin
            cascade_d = internal_data_bus;
            state_d   = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            sfnm_d  = internal_data_bus[4];
            buf_d   = internal_data_bus[3];
            ms_d    = internal_data_bus[2];
            aeoi_d  = internal_data_bus[1];
            upm_d   = internal_data_bus[0];
            state_d = READY;
          end
          READY:   imr_d = internal_data_bus;
          default: ;
        endcase
      end

      if (ocw2_ev && state_q == READY) begin
        level_d = internal_data_bus[2:0];
        case (internal_data_bus[7:5])
          3'b001: eoi_d = 1'b1;
          3'b011: begin eoi_d = 1'b1; specific_d = 1'b1; end
          3'b101: begin eoi_d = 1'b1; rotate_d = 1'b1; end
          3'b111: begin eoi_d = 1'b1; rotate_d = 1'b1; specific_d = 1'b1; end
          3'b100: raeoi_d = 1'b1;
          3'b000: raeoi_d = 1'b0;
          3'b110: begin setpri_d = 1'b1; specific_d = 1'b1; end
          default: ;
        endcase
      end

      if (ocw3_ev && state_q == READY) begin
        if (internal_data_bus[6]) smm_d = internal_data_bus[5];
        if (internal_data_bus[1]) ris_d = internal_data_bus[0];
        poll_d = internal_data_bus[2];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_ICW1;
      prev_icw1_q  <= 1'b1;
      prev_icw24_q <= 1'b1;
      prev_ocw1_q  <= 1'b1;
      prev_ocw2_q  <= 1'b1;
      prev_ocw3_q  <= 1'b1;
      ltim_q       <= 1'b0;
      sngl_q       <= 1'b0;
      ic4_q        <= 1'b0;
      vector_q     <= 5'd0;
      cascade_q    <= 8'h00;
      sfnm_q       <= 1'b0;
      buf_q        <= 1'b0;
      ms_q         <= 1'b0;
      aeoi_q       <= 1'b0;
      upm_q        <= 1'b0;
      imr_q        <= 8'h00;
      smm_q        <= 1'b0;
      ris_q        <= 1'b0;
      raeoi_q      <= 1'b0;
      eoi_q        <= 1'b0;
      specific_q   <= 1'b0;
      rotate_q     <= 1'b0;
      setpri_q     <= 1'b0;
      level_q      <= 3'd0;
      poll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_icw1_q  <= prev_icw1_d;
      prev_icw24_q <= prev_icw24_d;
      prev_ocw1_q  <= prev_ocw1_d;
      prev_ocw2_q  <= prev_ocw2_d;
      prev_ocw3_q  <= prev_ocw3_d;
      ltim_q       <= ltim_d;
      sngl_q       <= sngl_d;
      ic4_q        <= ic4_d;
      vector_q     <= vector_d;
      cascade_q    <= cascade_d;
      sfnm_q       <= sfnm_d;
      buf_q        <= buf_d;
      ms_q         <= ms_d;
      aeoi_q       <= aeoi_d;
      upm_q        <= upm_d;
      imr_q        <= imr_d;
      smm_q        <= smm_d;
      ris_q        <= ris_d;
      raeoi_q      <= raeoi_d;
      eoi_q        <= eoi_d;
      specific_q   <= specific_d;
      rotate_q     <= rotate_d;
      setpri_q     <= setpri_d;
      level_q      <= level_d;
      poll_q       <= poll_d;
    end
  end

  assign initialization_complete        = (state_q == READY);
  assign level_or_edge_triggered_config = ltim_q;
  assign single_mode                    = sngl_q;
  assign interrupt_vector_address       = vector_q;
  assign cascade_device_config          = cascade_q;
  assign buffered_mode                  = buf_q;
  assign buffered_master                = ms_q;
  assign special_fully_nested           = sfnm_q;
  assign auto_eoi                       = aeoi_q;
  assign microprocessor_mode            = upm_q;
  assign interrupt_mask                 = imr_q;
  assign special_mask_mode              = smm_q;
  assign read_register_isr              = ris_q;
  assign rotate_on_auto_eoi             = raeoi_q;
  assign end_of_interrupt               = eoi_q;
  assign specific_command               = specific_q;
  assign rotate_command                 = rotate_q;
  assign set_priority                   = setpri_q;
  assign command_level                  = level_q;
  assign poll_command                   = poll_q;

endmodule

// File: tb/tb_control_word_registers_8259.sv
// tb/tb_control_word_registers_8259.sv - directed self-checking bench for control_word_registers_8259

module tb_control_word_registers_8259;

  logic       clock;
  logic       reset_n;
  logic       w_icw1;
  logic       w_icw24;
  logic       w_ocw1;
  logic       w_ocw2;
  logic       w_ocw3;
  logic [7:0] bus;

  logic       init_done;
  logic       ltim;
  logic       sngl;
  logic [4:0] vector;
  logic [7:0] cascade;
  logic       buf_mode;
  logic       buf_master;
  logic       sfnm;
  logic       aeoi;
  logic       upm;
  logic [7:0] imr;
  logic       smm;
  logic       ris;
  logic       raeoi;
  logic       eoi;
  logic       specific;
  logic       rotate;
  logic       setpri;
  logic [2:0] level;
  logic       poll;

  int checks = 0;
  int errors = 0;

  control_word_registers_8259 dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .write_initial_command_word_1   (w_icw1),
    .write_initial_command_word_2_4 (w_icw24),
    .write_operation_control_word_1 (w_ocw1),
    .write_operation_control_word_2 (w_ocw2),
    .write_operation_control_word_3 (w_ocw3),
    .internal_data_bus              (bus),
    .initialization_complete        (init_done),
    .level_or_edge_triggered_config (ltim),
    .single_mode                    (sngl),
    .interrupt_vector_address       (vector),
    .cascade_device_config          (cascade),
    .buffered_mode                  (buf_mode),
    .buffered_master                (buf_master),
    .special_fully_nested           (sfnm),
    .auto_eoi                       (aeoi),
    .microprocessor_mode            (upm),
    .interrupt_mask                 (imr),
    .special_mask_mode              (smm),
    .read_register_isr              (ris),
    .rotate_on_auto_eoi             (raeoi),
    .end_of_interrupt               (eoi),
    .specific_command               (specific),
    .rotate_command                 (rotate),
    .set_priority                   (setpri),
    .command_level                  (level),
    .poll_command                   (poll)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // which: 1=ICW1, 2=ICW2-4 A0 strobe, 4=OCW1 A0 strobe, 5=OCW2, 6=OCW3.
  // Raises the strobe at a falling edge, lowers it one cycle later; on return
  // the sampling point is the falling edge right after the acting rising edge.
  task automatic do_write(input int which, input logic [7:0] data);
    @(negedge clock);
    bus = data;
    case (which)
      1: w_icw1  = 1'b1;
      2: w_icw24 = 1'b1;
      4: w_ocw1  = 1'b1;
      5: w_ocw2  = 1'b1;
      6: w_ocw3  = 1'b1;
      default: ;
    endcase
    @(negedge clock);
    w_icw1  = 1'b0;
    w_icw24 = 1'b0;
    w_ocw1  = 1'b0;
    w_ocw2  = 1'b0;
    w_ocw3  = 1'b0;
  endtask

  task automatic all_zero_check(input string tag);
    check({tag, "_done"},    {7'd0, init_done}, 8'h00);
    check({tag, "_vector"},  {3'd0, vector},    8'h00);
    check({tag, "_cascade"}, cascade,           8'h00);
    check({tag, "_imr"},     imr,               8'h00);
    check({tag, "_flags"},   {ltim, sngl, buf_mode, buf_master, sfnm, aeoi, upm, smm}, 8'h00);
    check({tag, "_flags2"},  {ris, raeoi, eoi, specific, rotate, setpri, poll, 1'b0}, 8'h00);
    check({tag, "_level"},   {5'd0, level},     8'h00);
  endtask

  initial begin
    reset_n = 1'b0;
    w_icw1  = 1'b0;
    w_icw24 = 1'b0;
    w_ocw1  = 1'b0;
    w_ocw2  = 1'b0;
    w_ocw3  = 1'b0;
    bus     = 8'h00;
    repeat (3) @(negedge clock);
    all_zero_check("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // OCW2 before initialisation has no effect.
    do_write(5, 8'h20);
    check("pre_init_eoi", {7'd0, eoi}, 8'h00);

    // Single, with ICW4.
    do_write(1, 8'h13);
    check("t1_sngl", {7'd0, sngl}, 8'h01);
    check("t1_done_icw1", {7'd0, init_done}, 8'h00);
    do_write(2, 8'h48);
    check("t1_vector", {3'd0, vector}, 8'h09);
    check("t1_done_icw2", {7'd0, init_done}, 8'h00);
    do_write(2, 8'h03);
    check("t1_aeoi_upm", {6'd0, aeoi, upm}, 8'h03);
    check("t1_done_icw4", {7'd0, init_done}, 8'h01);

    // Cascade with ICW3 and ICW4.
    do_write(1, 8'h11);
    check("t2_done_icw1", {7'd0, init_done}, 8'h00);
    do_write(2, 8'h20);
    check("t2_vector", {3'd0, vector}, 8'h04);
    check("t2_done_icw2", {7'd0, init_done}, 8'h00);
    do_write(2, 8'h04);
    check("t2_cascade", cascade, 8'h04);
    check("t2_done_icw3", {7'd0, init_done}, 8'h00);
    do_write(2, 8'h1D);
    check("t2_icw4", {3'd0, sfnm, buf_mode, buf_master, aeoi, upm}, 8'h1D);
    check("t2_done_icw4", {7'd0, init_done}, 8'h01);

    // Single, no ICW4; IMR via OCW1 strobe; ICW1 clears IMR.
    do_write(1, 8'h12);
    do_write(2, 8'h40);
    check("t3_done", {7'd0, init_done}, 8'h01);
    check("t3_icw4_clear", {3'd0, sfnm, buf_mode, buf_master, aeoi, upm}, 8'h00);
    do_write(4, 8'hF0);
    check("t3_imr", imr, 8'hF0);
    // IMR write through the ICW2-4 strobe while READY is also OCW1.
    do_write(2, 8'h5A);
    check("t3_imr_alt", imr, 8'h5A);

    // Simultaneous A0 strobes count once (only one IMR write either way; here
    // checked through a sequence where a double count would advance state).
    do_write(1, 8'h12);
    check("t3_imr_cleared", imr, 8'h00);
    @(negedge clock);
    bus = 8'h40;
    w_icw24 = 1'b1;
    w_ocw1  = 1'b1;
    @(negedge clock);
    w_icw24 = 1'b0;
    w_ocw1  = 1'b0;
    check("dual_a0_done", {7'd0, init_done}, 8'h01);
    check("dual_a0_imr", imr, 8'h00);

    // OCW2 commands.
    do_write(5, 8'h63);
    check("eoi_spec_pulse", {5'd0, eoi, specific, rotate}, 8'h06);
    check("eoi_spec_level", {5'd0, level}, 8'h03);
    @(negedge clock);
    check("eoi_spec_gone", {5'd0, eoi, specific, rotate}, 8'h00);
    do_write(5, 8'hA0);
    check("eoi_rot_pulse", {5'd0, eoi, specific, rotate}, 8'h05);
    @(negedge clock);
    check("eoi_rot_gone", {7'd0, eoi}, 8'h00);
    do_write(5, 8'h80);
    check("raeoi_set", {6'd0, raeoi, eoi}, 8'h02);
    do_write(5, 8'hC5);
    check("setpri_pulse", {5'd0, setpri, specific, eoi}, 8'h06);
    check("setpri_level", {5'd0, level}, 8'h05);
    @(negedge clock);
    check("setpri_gone", {7'd0, setpri}, 8'h00);
    do_write(5, 8'h00);
    check("raeoi_clr", {7'd0, raeoi}, 8'h00);

    // Held strobe gives only one event.
    @(negedge clock);
    bus = 8'h20;
    w_ocw2 = 1'b1;
    @(negedge clock);
    check("held_first", {7'd0, eoi}, 8'h01);
    repeat (3) begin
      @(negedge clock);
      check("held_no_repeat", {7'd0, eoi}, 8'h00);
    end
    w_ocw2 = 1'b0;

    // OCW3.
    do_write(6, 8'h0B);
    check("ocw3_isr", {7'd0, ris}, 8'h01);
    do_write(6, 8'h0A);
    check("ocw3_irr", {7'd0, ris}, 8'h00);
    do_write(6, 8'h0C);
    check("poll_pulse", {6'd0, poll, ris}, 8'h02);
    @(negedge clock);
    check("poll_gone", {7'd0, poll}, 8'h00);
    do_write(6, 8'h68);
    check("smm_set", {7'd0, smm}, 8'h01);
    do_write(6, 8'h48);
    check("smm_clr", {7'd0, smm}, 8'h00);

    // Reset mid-sequence, strobes held across release.
    do_write(1, 8'h11);
    do_write(2, 8'h48);
    check("pre_reset_vector", {3'd0, vector}, 8'h09);
    #2;
    reset_n = 1'b0;
    #1;
    all_zero_check("async_reset");
    @(negedge clock);
    w_icw1  = 1'b1;
    w_icw24 = 1'b1;
    bus = 8'h13;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("held_release_sngl", {7'd0, sngl}, 8'h00);
    w_icw1  = 1'b0;
    w_icw24 = 1'b0;
    // Still in WAIT_ICW1, so an A0 write must be ignored.
    do_write(2, 8'h48);
    check("wait_icw1_ignore", {3'd0, vector}, 8'h00);
    check("wait_icw1_done", {7'd0, init_done}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_word_registers_8259.md
# control_word_registers_8259

Control-word sequencer and register file for the 8259A, directly downstream of the data-bus/read-write decode stage. It consumes that stage's write strobes and `internal_data_bus`, sequences ICW1→ICW2→(ICW3)→(ICW4), and disambiguates A0=1 writes as ICW2/3/4 or OCW1. It holds all programmed configuration and emits single-cycle OCW2/OCW3 command pulses to the priority and in-service logic.

## Interface
No parameters. Ports (clock and reset first):
- `clock`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `write_initial_command_word_1`  in  1  ICW1 strobe (level; acted on at rise)
- `write_initial_command_word_2_4`  in  1  A0=1 write strobe, ICW2–4 role
- `write_operation_control_word_1`  in  1  A0=1 write strobe, OCW1 role (same timing as above)
- `write_operation_control_word_2`  in  1  OCW2 strobe
- `write_operation_control_word_3`  in  1  OCW3 strobe
- `internal_data_bus`  in  8  latched write data; stable while any strobe rises
- `initialization_complete`  out  1  sequence finished (state READY)
- `level_or_edge_triggered_config`  out  1  ICW1 D3 (LTIM)
- `single_mode`  out  1  ICW1 D1 (SNGL)
- `interrupt_vector_address`  out  5  ICW2 D7:D3
- `cascade_device_config`  out  8  ICW3 byte
- `buffered_mode` / `buffered_master`  out  1 each  ICW4 D3 / D2
- `special_fully_nested`  out  1  ICW4 D4
- `auto_eoi`  out  1  ICW4 D1
- `microprocessor_mode`  out  1  ICW4 D0
- `interrupt_mask`  out  8  IMR (OCW1)
- `special_mask_mode`  out  1  OCW3 SMM
- `read_register_isr`  out  1  1=ISR, 0=IRR selected for reads
- `rotate_on_auto_eoi`  out  1  OCW2 rotate-in-AEOI flag
- `end_of_interrupt`  out  1  one-cycle pulse, EOI command
- `specific_command`  out  1  qualifies pulses: 1=use `command_level`
- `rotate_command`  out  1  qualifies `end_of_interrupt`: rotate priority
- `set_priority`  out  1  one-cycle pulse, OCW2 set-priority (110)
- `command_level`  out  3  OCW2 L2:L0, latched on every OCW2
- `poll_command`  out  1  one-cycle pulse, OCW3 P=1

## Operation
- Each strobe has an edge register (reset value 1); event = strobe & ~prev. A strobe already high at reset release never fires.
- States: WAIT_ICW1 (reset), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 event, any state: latch LTIM, SNGL, IC4 (D0); IMR←0, special_mask_mode←0, read_register_isr←0, rotate_on_auto_eoi←0, ICW4 fields←0; →WAIT_ICW2. D7:D5, D2 ignored.
- A0=1 event (either A0=1 strobe; rising together counts once): WAIT_ICW1 ignore; WAIT_ICW2 latch vector, →WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY; WAIT_ICW3 latch cascade config, →WAIT_ICW4 if IC4 else READY; WAIT_ICW4 latch ICW4 fields, →READY; READY IMR←bus.
- OCW2/OCW3 events outside READY are ignored.
- OCW2 (R,SL,EOI = D7:D5): 001 EOI; 011 EOI+specific; 101 EOI+rotate; 111 EOI+rotate+specific; 100 rotate_on_auto_eoi←1; 000 ←0; 110 set_priority pulse, specific=1; 010 no-op.
- OCW3: D6=1 → special_mask_mode←D5; D1=1 → read_register_isr←D0; D2=1 → poll pulse.
- Reset values: all outputs 0, state WAIT_ICW1.

## Timing
- Event sampled at edge N (strobe high at N, low at N−1): registers and state update at edge N; visible cycle after N.
- Pulses (`end_of_interrupt`, `set_priority`, `poll_command`) high exactly one cycle after edge N; `specific_command`/`rotate_command` valid during that cycle.
- Strobe held high: no further events until it falls and rises again.
- Back-to-back writes need ≥1 low cycle per strobe between rises.
- `reset_n` low mid-sequence: immediate return to reset values, pending pulses cleared.

## Test plan
- ICW1=0x13, ICW2=0x48, ICW4=0x03 → vector 0x09, single_mode=1, auto_eoi=1, microprocessor_mode=1, initialization_complete=1 after ICW4 edge only.
- ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x1D → cascade_device_config=0x04, special_fully_nested=1, buffered_mode=1, buffered_master=1, READY.
- ICW1=0x12, ICW2=0x40 → READY without ICW4, ICW4 fields 0; A0=1 write 0xF0 → interrupt_mask=0xF0; new ICW1 → mask 0x00.
- READY, OCW2 0x63 → one-cycle end_of_interrupt, specific=1, level=3; 0xA0 → EOI+rotate; 0x80 → rotate_on_auto_eoi=1; 0xC5 → set_priority, level=5.
- OCW3 0x0B → read_register_isr=1; 0x0A → 0; 0x0C → one poll pulse, select unchanged; 0x68 → special_mask_mode=1; OCW2 before init → no pulse.
- After ICW1+ICW2, pulse reset_n low → all outputs 0, WAIT_ICW1; A0=1 strobe held high across release → no event.
